nmt_context_scheduler: RTL and testbench



---
 rtl/nmt_context_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_nmt_context_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nmt_context_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nmt_context_scheduler
// Brief    : Hands the NMT pipeline between the resident near-memory thread
//            and the host. A host access to the thread's live address starts
//            a switch-out. The per-stage MPR selects then walk over one stage
//            per cycle. The host holds the pipeline until the controller frees
//            the saved address, and the selects then walk back.
// Options  : `define NMT_STARVATION_GUARD_EN to bound host ownership to
//            MAX_HOST_CYCLES and add the guard_timeout pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module nmt_context_scheduler #(
  parameter int ADDR_W          = 9,
  parameter int NUM_STAGES      = 4,
  parameter int CNT_W           = 16,
  parameter int MAX_HOST_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic                  nmt_valid,
  input  logic [ADDR_W-1:0]     nmt_addr,
  input  logic                  freed,
  input  logic [ADDR_W-1:0]     freed_addr,
  output logic                  context_switch,
  output logic [NUM_STAGES-1:0] stage_select,
  output logic                  active_thread,
  output logic [ADDR_W-1:0]     saved_addr,
  output logic                  busy,
`ifdef NMT_STARVATION_GUARD_EN
  output logic                  guard_timeout,
`endif
  output logic [CNT_W-1:0]      switch_count
);

  typedef enum logic [1:0] {
    NMT_RUN    = 2'd0,
    SWITCH_OUT = 2'd1,
    HOST_OWN   = 2'd2,
    SWITCH_IN  = 2'd3
  } state_t;

  localparam int                c_IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

  // A zero host-ownership limit would make the guard fire on entry.
  if (MAX_HOST_CYCLES < 1) begin : g_bad_max_host_cycles
    $error("MAX_HOST_CYCLES must be at least 1");
  end

  state_t                r_state, w_state;
  logic [c_IDX_W-1:0]    r_idx, w_idx;
  logic                  r_pending, w_pending;
  logic                  r_cs, w_cs;
  logic [NUM_STAGES-1:0] r_sel, w_sel;
  logic                  r_active, w_active;
  logic [ADDR_W-1:0]     r_saved, w_saved;
  logic [CNT_W-1:0]      r_count, w_count;

  logic w_collision;
  logic w_free_match;
  logic w_release;
  logic w_force;

  assign w_collision  = host_req & nmt_valid & (host_addr == nmt_addr);
  assign w_free_match = freed & (freed_addr == r_saved);
  assign w_release    = w_free_match | r_pending;

`ifdef NMT_STARVATION_GUARD_EN
  localparam int                 c_HCNT_W    = (MAX_HOST_CYCLES > 1) ? $clog2(MAX_HOST_CYCLES) : 1;
  localparam logic [c_HCNT_W-1:0] c_HCNT_LAST = c_HCNT_W'(MAX_HOST_CYCLES - 1);

  logic [c_HCNT_W-1:0] r_hcnt, w_hcnt;
  logic                r_timeout;

  // Forced exit only when this is the last allowed host cycle and nothing freed us.
  assign w_force       = ~w_release & (r_hcnt == c_HCNT_LAST);
  assign guard_timeout = r_timeout;
`else
  assign w_force = 1'b0;
`endif

  // Next-state and next-output computation for the ownership sequence.
  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_pending = r_pending;
    w_cs      = 1'b0;
    w_sel     = r_sel;
    w_active  = r_active;
    w_saved   = r_saved;
    w_count   = r_count;
`ifdef NMT_STARVATION_GUARD_EN
    w_hcnt    = r_hcnt;
`endif
    case (r_state)
      NMT_RUN: begin
        // freed is ignored here: no context has been saved yet.
        if (w_collision) begin
          w_cs    = 1'b1;
          w_saved = nmt_addr;
          w_idx   = '0;
          if (r_count != c_CNT_MAX) begin
            w_count = r_count + CNT_W'(1);
          end
          w_state = SWITCH_OUT;
        end
      end
      SWITCH_OUT: begin
        w_sel[r_idx] = 1'b1;
        // A release arriving mid-walk is remembered and honoured in HOST_OWN.
        if (w_free_match) begin
          w_pending = 1'b1;
        end
        if (r_idx == c_LAST_IDX) begin
          w_active = 1'b1;
          w_state  = HOST_OWN;
`ifdef NMT_STARVATION_GUARD_EN
          w_hcnt   = '0;
`endif
        end else begin
          w_idx = r_idx + c_IDX_W'(1);
        end
      end
      HOST_OWN: begin
        w_sel = '1;
`ifdef NMT_STARVATION_GUARD_EN
        w_hcnt = r_hcnt + c_HCNT_W'(1);
`endif
        if (w_release | w_force) begin
          w_pending = 1'b0;
          w_idx     = '0;
          w_active  = 1'b0;
          w_state   = SWITCH_IN;
        end
      end
      SWITCH_IN: begin
        w_sel[r_idx] = 1'b0;
        if (r_idx == c_LAST_IDX) begin
          w_state = NMT_RUN;
        end else begin
          w_idx = r_idx + c_IDX_W'(1);
        end
      end
      default: begin
        w_state = NMT_RUN;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset abandoning any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NMT_RUN;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_cs      <= 1'b0;
      r_sel     <= '0;
      r_active  <= 1'b0;
      r_saved   <= '0;
      r_count   <= '0;
`ifdef NMT_STARVATION_GUARD_EN
      r_hcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_pending <= w_pending;
      r_cs      <= w_cs;
      r_sel     <= w_sel;
      r_active  <= w_active;
      r_saved   <= w_saved;
      r_count   <= w_count;
`ifdef NMT_STARVATION_GUARD_EN
      r_hcnt    <= w_hcnt;
      r_timeout <= (r_state == HOST_OWN) & w_force;
`endif
    end
  end

  assign context_switch = r_cs;
  assign stage_select   = r_sel;
  assign active_thread  = r_active;
  assign saved_addr     = r_saved;
  assign switch_count   = r_count;
  assign busy           = (r_state != NMT_RUN);

endmodule
`default_nettype wire

// File: tb/tb_nmt_context_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmt_context_scheduler
// Brief    : Directed plus random stimulus for nmt_context_scheduler, checked
//            every cycle against a timeline model of the ownership handover.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmt_context_scheduler;

  localparam int ADDR_W = 9;
  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int MAXH   = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic              nmt_valid;
  logic [ADDR_W-1:0] nmt_addr;
  logic              freed;
  logic [ADDR_W-1:0] freed_addr;
  logic              context_switch;
  logic [N-1:0]      stage_select;
  logic              active_thread;
  logic [ADDR_W-1:0] saved_addr;
  logic              busy;
  logic [CNT_W-1:0]  switch_count;
`ifdef NMT_STARVATION_GUARD_EN
  logic              guard_timeout;
`endif

  always #5 clk = ~clk;

  nmt_context_scheduler #(
    .ADDR_W(ADDR_W), .NUM_STAGES(N), .CNT_W(CNT_W), .MAX_HOST_CYCLES(MAXH)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_addr(host_addr),
    .nmt_valid(nmt_valid), .nmt_addr(nmt_addr),
    .freed(freed), .freed_addr(freed_addr),
    .context_switch(context_switch), .stage_select(stage_select),
    .active_thread(active_thread), .saved_addr(saved_addr),
    .busy(busy),
`ifdef NMT_STARVATION_GUARD_EN
    .guard_timeout(guard_timeout),
`endif
    .switch_count(switch_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Timeline model: k counts cycles since the switch began (k=1 is the
  // context_switch cycle); rel is the host cycle on which release was decided.
  bit                m_in_use;
  int                m_k;
  int                m_rel;
  bit                m_free_seen;
  logic [ADDR_W-1:0] m_saved;
  logic [CNT_W-1:0]  m_count;
  bit                m_timeout;

  task automatic model_edge();
    bit match;
    m_timeout = 1'b0;
    if (rst) begin
      m_in_use = 0; m_k = 0; m_rel = -1; m_free_seen = 0;
      m_saved = '0; m_count = '0;
    end else if (!m_in_use) begin
      if (host_req && nmt_valid && host_addr == nmt_addr) begin
        m_in_use = 1; m_k = 1; m_rel = -1; m_free_seen = 0;
        m_saved = nmt_addr;
        if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
      end
    end else begin
      match = freed && (freed_addr == m_saved);
      if (m_rel < 0) begin
        if (m_k <= N) begin
          if (match) m_free_seen = 1;
        end else if (match || m_free_seen) begin
          m_rel = m_k;
        end else begin
`ifdef NMT_STARVATION_GUARD_EN
          if (m_k - N == MAXH) begin
            m_rel = m_k;
            m_timeout = 1'b1;
          end
`endif
        end
      end
      m_k = m_k + 1;
      if (m_rel >= 0 && m_k == m_rel + N + 1) m_in_use = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int all_ones;
    int e_sel;
    bit e_act;
    all_ones = (1 << N) - 1;
    if (!m_in_use) begin
      e_sel = 0; e_act = 0;
    end else if (m_rel < 0) begin
      e_sel = (m_k <= N) ? ((1 << (m_k - 1)) - 1) : all_ones;
      e_act = (m_k > N);
    end else begin
      e_sel = (all_ones << (m_k - m_rel - 1)) & all_ones;
      e_act = 0;
    end
    chk("context_switch", 32'(context_switch), 32'(m_in_use && m_k == 1));
    chk("stage_select",   32'(stage_select),   32'(e_sel));
    chk("active_thread",  32'(active_thread),  32'(e_act));
    chk("saved_addr",     32'(saved_addr),     32'(m_saved));
    chk("busy",           32'(busy),           32'(m_in_use));
    chk("switch_count",   32'(switch_count),   32'(m_count));
`ifdef NMT_STARVATION_GUARD_EN
    chk("guard_timeout",  32'(guard_timeout),  32'(m_timeout));
`endif
  endtask

  task automatic step(input bit r, input bit hr, input logic [ADDR_W-1:0] ha,
                      input bit nv, input logic [ADDR_W-1:0] na,
                      input bit fr, input logic [ADDR_W-1:0] fa);
    rst = r; host_req = hr; host_addr = ha; nmt_valid = nv; nmt_addr = na;
    freed = fr; freed_addr = fa;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 9'h000, 1, 9'h05A, 0, 9'h000);
  endtask

  initial begin
    logic [ADDR_W-1:0] na;
    logic [ADDR_W-1:0] ha;
    logic [ADDR_W-1:0] fa;
    bit                r;

    // Reset and quiet idle.
    step(1, 0, 9'h000, 0, 9'h000, 0, 9'h000);
    step(1, 0, 9'h000, 0, 9'h000, 0, 9'h000);
    idle(10);

    // Collision, walk out, ignore foreign free, matching free walks back.
    step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    idle(7);
    step(0, 0, 9'h000, 1, 9'h05A, 1, 9'h033);
    step(0, 0, 9'h000, 1, 9'h05A, 1, 9'h033);
    step(0, 0, 9'h000, 1, 9'h05A, 1, 9'h05A);
    idle(6);

    // Matching free during the second switch-out cycle is remembered.
    step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    idle(1);
    step(0, 0, 9'h000, 1, 9'h05A, 1, 9'h05A);
    idle(10);

    // Back-to-back: collision held throughout, accepted again right after SWITCH_IN.
    step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    for (int i = 0; i < 6; i++) step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    step(0, 1, 9'h05A, 1, 9'h05A, 1, 9'h05A);
    for (int i = 0; i < 8; i++) step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    step(0, 0, 9'h000, 1, 9'h05A, 1, 9'h05A);
    idle(6);

    // Near-misses: address mismatch, and matching address with no live thread.
    step(0, 1, 9'h05B, 1, 9'h05A, 0, 9'h000);
    step(0, 1, 9'h05A, 0, 9'h05A, 0, 9'h000);
    idle(2);

    // Reset in the third switch-out cycle.
    step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    idle(2);
    step(1, 0, 9'h000, 1, 9'h05A, 0, 9'h000);
    idle(3);

    // Random traffic over a small address set so collisions and frees are common.
    na = 9'h05A;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) na = ($urandom_range(0, 1) == 1) ? 9'h05A : 9'(($urandom_range(0, 511)));
      ha = ($urandom_range(0, 1) == 1) ? na : 9'($urandom_range(0, 511));
      fa = ($urandom_range(0, 2) != 0) ? m_saved : 9'($urandom_range(0, 511));
      r  = ($urandom_range(0, 199) == 0);
      step(r, $urandom_range(0, 2) == 0, ha, $urandom_range(0, 3) != 0, na,
           $urandom_range(0, 5) == 0, fa);
    end

`ifdef NMT_STARVATION_GUARD_EN
    // Collide and never free: the guard must force the walk back.
    idle(12);
    step(0, 1, 9'h05A, 1, 9'h05A, 0, 9'h000);
    idle(MAXH + 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
